jtvigil_snd_if: RTL and testbench

JTVIGIL_SND_IF -- requirements
Module: jtvigil_snd_if

---
 rtl/jtvigil_snd_if.sv | 114 +++++++++++
 tb/tb_jtvigil_snd_if.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/jtvigil_snd_if.sv
// ============================================================================
//  Module      : jtvigil_snd_if
//  Description : Main-to-sound CPU latch pair, interrupt logic and optional
//                sample ROM address counter (enabled by JTVIGIL_SAMPLE_EN).
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module jtvigil_snd_if (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  main_dout,
    input  logic        snd_latch0_cs,
    input  logic        snd_latch1_cs,
    input  logic        snd_int,
    input  logic        sres_b,
    input  logic        snd_cen,
    input  logic [7:0]  snd_dout,
    input  logic        lat0_rd,
    input  logic        lat1_rd,
    input  logic        irq_ack,
    input  logic        ym_irq_n,
    input  logic        smp_lo_we,
    input  logic        smp_hi_we,
    input  logic        smp_inc,
    output logic [7:0]  snd_din,
    output logic        int_n,
    output logic [7:0]  int_vec,
    output logic [1:0]  pend,
    output logic [15:0] smp_addr
);

    localparam logic [7:0] c_IDLE_BUS = 8'hFF;

    logic [7:0] latch0_q, latch0_d;
    logic [7:0] latch1_q, latch1_d;
    logic [1:0] pend_q,   pend_d;
    logic       snd_int_q;
    logic       int_n_q,  int_n_d;
    logic       w_int_rise;

    assign w_int_rise = snd_int & ~snd_int_q;

    always_comb begin
        latch0_d = snd_latch0_cs ? main_dout : latch0_q;
        latch1_d = snd_latch1_cs ? main_dout : latch1_q;
        // Set terms come last so a same-cycle set beats the clear
        pend_d   = pend_q;
        if (irq_ack && snd_cen) pend_d[0] = 1'b0;
        if (lat1_rd && snd_cen) pend_d[1] = 1'b0;
        if (snd_latch0_cs || w_int_rise) pend_d[0] = 1'b1;
        if (snd_latch1_cs) pend_d[1] = 1'b1;
        if (!sres_b) pend_d = 2'b00;
        int_n_d  = sres_b ? ~(pend_q[0] | ~ym_irq_n) : 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            latch0_q  <= 8'h00;
            latch1_q  <= 8'h00;
            pend_q    <= 2'b00;
            snd_int_q <= 1'b0;
            int_n_q   <= 1'b1;
        end else begin
            latch0_q  <= latch0_d;
            latch1_q  <= latch1_d;
            pend_q    <= pend_d;
            snd_int_q <= snd_int;
            int_n_q   <= int_n_d;
        end
    end

    always_comb begin
        if (lat0_rd)      snd_din = latch0_q;
        else if (lat1_rd) snd_din = latch1_q;
        else              snd_din = c_IDLE_BUS;
    end

    // RST vector: bit 5 low for the latch source, bit 4 low for the FM chip
    assign int_vec = {2'b11, ~pend_q[0], ym_irq_n, 4'hF};
    assign int_n   = int_n_q;
    assign pend    = pend_q;

`ifdef JTVIGIL_SAMPLE_EN
    logic [15:0] smp_addr_q, smp_addr_d;

    always_comb begin
        smp_addr_d = smp_addr_q;
        if (snd_cen) begin
            if (smp_lo_we || smp_hi_we) begin
                if (smp_lo_we) smp_addr_d[7:0]  = snd_dout;
                if (smp_hi_we) smp_addr_d[15:8] = snd_dout;
            end else if (smp_inc) begin
                smp_addr_d = smp_addr_q + 16'd1;
            end
        end
        if (!sres_b) smp_addr_d = 16'h0000;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) smp_addr_q <= 16'h0000;
        else        smp_addr_q <= smp_addr_d;
    end

    assign smp_addr = smp_addr_q;
`else
    logic w_unused;
    assign w_unused = &{1'b0, smp_lo_we, smp_hi_we, smp_inc, snd_dout};
    assign smp_addr = 16'h0000;
`endif

endmodule

`default_nettype wire

// File: tb/tb_jtvigil_snd_if.sv
// ============================================================================
//  Module      : tb_jtvigil_snd_if
//  Description : Directed self-checking bench for jtvigil_snd_if.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_jtvigil_snd_if;

    logic        clk = 1'b0;
    logic        rst_n, snd_latch0_cs, snd_latch1_cs, snd_int, sres_b, snd_cen;
    logic [7:0]  main_dout, snd_dout;
    logic        lat0_rd, lat1_rd, irq_ack, ym_irq_n, smp_lo_we, smp_hi_we, smp_inc;
    logic [7:0]  snd_din, int_vec;
    logic        int_n;
    logic [1:0]  pend;
    logic [15:0] smp_addr;

    int total = 0;
    int bad   = 0;

    jtvigil_snd_if dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .main_dout     (main_dout),
        .snd_latch0_cs (snd_latch0_cs),
        .snd_latch1_cs (snd_latch1_cs),
        .snd_int       (snd_int),
        .sres_b        (sres_b),
        .snd_cen       (snd_cen),
        .snd_dout      (snd_dout),
        .lat0_rd       (lat0_rd),
        .lat1_rd       (lat1_rd),
        .irq_ack       (irq_ack),
        .ym_irq_n      (ym_irq_n),
        .smp_lo_we     (smp_lo_we),
        .smp_hi_we     (smp_hi_we),
        .smp_inc       (smp_inc),
        .snd_din       (snd_din),
        .int_n         (int_n),
        .int_vec       (int_vec),
        .pend          (pend),
        .smp_addr      (smp_addr)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; main_dout = 8'hAA; snd_latch0_cs = 1'b1; snd_latch1_cs = 1'b1;
        step(); step();
        snd_latch0_cs = 1'b0; snd_latch1_cs = 1'b0;
        total++; if (pend !== 2'b00) begin bad++; $display("FAIL reset_pend: got %b want 00", pend); end
        total++; if (int_n !== 1'b1) begin bad++; $display("FAIL reset_int_n: got %b want 1", int_n); end
        total++; if (int_vec !== 8'hFF) begin bad++; $display("FAIL reset_int_vec: got %h want ff", int_vec); end
        total++; if (smp_addr !== 16'h0000) begin bad++; $display("FAIL reset_smp: got %h want 0000", smp_addr); end
        rst_n = 1'b1;
        step();
        total++; if (snd_din !== 8'hFF) begin bad++; $display("FAIL reset_idle_bus: got %h want ff", snd_din); end
        lat0_rd = 1'b1; #1;
        total++; if (snd_din !== 8'h00) begin bad++; $display("FAIL reset_latch0: got %h want 00", snd_din); end
        lat0_rd = 1'b0;
    endtask

    task automatic test_latch0();
        main_dout = 8'h5A; snd_latch0_cs = 1'b1;
        step(); snd_latch0_cs = 1'b0;
        total++; if (pend !== 2'b01) begin bad++; $display("FAIL l0_pend: got %b want 01", pend); end
        total++; if (int_n !== 1'b1) begin bad++; $display("FAIL l0_int_n_latency: got %b want 1", int_n); end
        total++; if (int_vec !== 8'hDF) begin bad++; $display("FAIL l0_int_vec: got %h want df", int_vec); end
        step();
        total++; if (int_n !== 1'b0) begin bad++; $display("FAIL l0_int_n: got %b want 0", int_n); end
        lat0_rd = 1'b1; snd_cen = 1'b1; #1;
        total++; if (snd_din !== 8'h5A) begin bad++; $display("FAIL l0_read: got %h want 5a", snd_din); end
        step(); lat0_rd = 1'b0; snd_cen = 1'b0;
        total++; if (pend !== 2'b01) begin bad++; $display("FAIL l0_read_keeps_pend: got %b want 01", pend); end
        irq_ack = 1'b1;
        step();
        total++; if (pend !== 2'b01) begin bad++; $display("FAIL l0_ack_no_cen: got %b want 01", pend); end
        snd_cen = 1'b1;
        step(); irq_ack = 1'b0; snd_cen = 1'b0;
        total++; if (pend !== 2'b00) begin bad++; $display("FAIL l0_ack: got %b want 00", pend); end
        step();
        total++; if (int_n !== 1'b1) begin bad++; $display("FAIL l0_int_n_release: got %b want 1", int_n); end
    endtask

    task automatic test_latch1();
        main_dout = 8'h3C; snd_latch1_cs = 1'b1;
        step(); snd_latch1_cs = 1'b0;
        total++; if (pend !== 2'b10) begin bad++; $display("FAIL l1_pend: got %b want 10", pend); end
        step();
        total++; if (int_n !== 1'b1) begin bad++; $display("FAIL l1_no_int: got %b want 1", int_n); end
        lat1_rd = 1'b1; #1;
        total++; if (snd_din !== 8'h3C) begin bad++; $display("FAIL l1_read: got %h want 3c", snd_din); end
        step();
        total++; if (pend !== 2'b10) begin bad++; $display("FAIL l1_rd_no_cen: got %b want 10", pend); end
        snd_cen = 1'b1;
        step(); lat1_rd = 1'b0; snd_cen = 1'b0;
        total++; if (pend !== 2'b00) begin bad++; $display("FAIL l1_rd_clear: got %b want 00", pend); end
        lat0_rd = 1'b1; lat1_rd = 1'b1; #1;
        total++; if (snd_din !== 8'h5A) begin bad++; $display("FAIL rd_priority: got %h want 5a", snd_din); end
        lat0_rd = 1'b0; lat1_rd = 1'b0;
        ym_irq_n = 1'b0; #1;
        total++; if (int_vec !== 8'hEF) begin bad++; $display("FAIL vec_fm: got %h want ef", int_vec); end
        step();
        total++; if (int_n !== 1'b0) begin bad++; $display("FAIL int_n_fm: got %b want 0", int_n); end
        main_dout = 8'hC3; snd_latch0_cs = 1'b1;
        step(); snd_latch0_cs = 1'b0;
        total++; if (int_vec !== 8'hCF) begin bad++; $display("FAIL vec_both: got %h want cf", int_vec); end
        ym_irq_n = 1'b1; irq_ack = 1'b1; snd_cen = 1'b1;
        step(); irq_ack = 1'b0; snd_cen = 1'b0;
        total++; if (pend !== 2'b00) begin bad++; $display("FAIL both_ack: got %b want 00", pend); end
        step();
        total++; if (int_n !== 1'b1) begin bad++; $display("FAIL both_release: got %b want 1", int_n); end
    endtask

    task automatic test_snd_int();
        snd_int = 1'b1;
        step();
        total++; if (pend !== 2'b01) begin bad++; $display("FAIL sint_set: got %b want 01", pend); end
        lat0_rd = 1'b1; #1;
        total++; if (snd_din !== 8'hC3) begin bad++; $display("FAIL sint_latch_kept: got %h want c3", snd_din); end
        lat0_rd = 1'b0; irq_ack = 1'b1; snd_cen = 1'b1;
        step(); irq_ack = 1'b0; snd_cen = 1'b0;
        total++; if (pend !== 2'b00) begin bad++; $display("FAIL sint_level_no_reset: got %b want 00", pend); end
        snd_int = 1'b0;
        step(); snd_int = 1'b1;
        step(); snd_int = 1'b0;
        total++; if (pend !== 2'b01) begin bad++; $display("FAIL sint_second_edge: got %b want 01", pend); end
        irq_ack = 1'b1; snd_cen = 1'b1;
        step(); irq_ack = 1'b0; snd_cen = 1'b0;
        step();
    endtask

    task automatic test_collision();
        main_dout = 8'h99; snd_latch0_cs = 1'b1; snd_latch1_cs = 1'b1;
        irq_ack = 1'b1; lat1_rd = 1'b1; snd_cen = 1'b1;
        step();
        snd_latch0_cs = 1'b0; snd_latch1_cs = 1'b0; irq_ack = 1'b0; lat1_rd = 1'b0; snd_cen = 1'b0;
        total++; if (pend !== 2'b11) begin bad++; $display("FAIL collide_pend: got %b want 11", pend); end
        lat0_rd = 1'b1; #1;
        total++; if (snd_din !== 8'h99) begin bad++; $display("FAIL collide_latch0: got %h want 99", snd_din); end
        lat0_rd = 1'b0; lat1_rd = 1'b1; #1;
        total++; if (snd_din !== 8'h99) begin bad++; $display("FAIL collide_latch1: got %h want 99", snd_din); end
        irq_ack = 1'b1; snd_cen = 1'b1;
        step(); irq_ack = 1'b0; lat1_rd = 1'b0; snd_cen = 1'b0;
        total++; if (pend !== 2'b00) begin bad++; $display("FAIL collide_clear: got %b want 00", pend); end
        step();
    endtask

    task automatic test_sample();
`ifdef JTVIGIL_SAMPLE_EN
        snd_cen = 1'b1; snd_dout = 8'hFF; smp_lo_we = 1'b1;
        step(); smp_lo_we = 1'b0; smp_hi_we = 1'b1;
        total++; if (smp_addr !== 16'h00FF) begin bad++; $display("FAIL smp_lo: got %h want 00ff", smp_addr); end
        step(); smp_hi_we = 1'b0; smp_inc = 1'b1;
        total++; if (smp_addr !== 16'hFFFF) begin bad++; $display("FAIL smp_hi: got %h want ffff", smp_addr); end
        step();
        total++; if (smp_addr !== 16'h0000) begin bad++; $display("FAIL smp_wrap: got %h want 0000", smp_addr); end
        step(); smp_inc = 1'b0;
        total++; if (smp_addr !== 16'h0001) begin bad++; $display("FAIL smp_inc2: got %h want 0001", smp_addr); end
        snd_dout = 8'h10; smp_lo_we = 1'b1; smp_inc = 1'b1;
        step(); smp_lo_we = 1'b0; smp_inc = 1'b0;
        total++; if (smp_addr !== 16'h0010) begin bad++; $display("FAIL smp_load_wins: got %h want 0010", smp_addr); end
        snd_cen = 1'b0; smp_inc = 1'b1; smp_hi_we = 1'b1;
        step(); smp_inc = 1'b0; smp_hi_we = 1'b0;
        total++; if (smp_addr !== 16'h0010) begin bad++; $display("FAIL smp_no_cen: got %h want 0010", smp_addr); end
        snd_cen = 1'b1; snd_dout = 8'h12; smp_hi_we = 1'b1;
        step(); snd_dout = 8'h34; smp_hi_we = 1'b0; smp_lo_we = 1'b1;
        step(); smp_lo_we = 1'b0; snd_cen = 1'b0;
        total++; if (smp_addr !== 16'h1234) begin bad++; $display("FAIL smp_1234: got %h want 1234", smp_addr); end
`else
        snd_cen = 1'b1; snd_dout = 8'hFF; smp_lo_we = 1'b1; smp_hi_we = 1'b1; smp_inc = 1'b1;
        step(); step();
        smp_lo_we = 1'b0; smp_hi_we = 1'b0; smp_inc = 1'b0; snd_cen = 1'b0;
        total++; if (smp_addr !== 16'h0000) begin bad++; $display("FAIL smp_disabled: got %h want 0000", smp_addr); end
`endif
    endtask

    task automatic test_sres();
        main_dout = 8'hA5; snd_latch0_cs = 1'b1; snd_latch1_cs = 1'b1;
        step(); snd_latch0_cs = 1'b0; snd_latch1_cs = 1'b0;
        total++; if (pend !== 2'b11) begin bad++; $display("FAIL sres_pre_pend: got %b want 11", pend); end
        step();
        total++; if (int_n !== 1'b0) begin bad++; $display("FAIL sres_pre_int: got %b want 0", int_n); end
        sres_b = 1'b0;
        step();
        total++; if (pend !== 2'b00) begin bad++; $display("FAIL sres_pend: got %b want 00", pend); end
        total++; if (int_n !== 1'b1) begin bad++; $display("FAIL sres_int_n: got %b want 1", int_n); end
        total++; if (smp_addr !== 16'h0000) begin bad++; $display("FAIL sres_smp: got %h want 0000", smp_addr); end
        lat0_rd = 1'b1; #1;
        total++; if (snd_din !== 8'hA5) begin bad++; $display("FAIL sres_latch0_kept: got %h want a5", snd_din); end
        lat0_rd = 1'b0; lat1_rd = 1'b1; #1;
        total++; if (snd_din !== 8'hA5) begin bad++; $display("FAIL sres_latch1_kept: got %h want a5", snd_din); end
        lat1_rd = 1'b0;
        main_dout = 8'h77; snd_latch0_cs = 1'b1; ym_irq_n = 1'b0;
        step(); snd_latch0_cs = 1'b0;
        total++; if (pend !== 2'b00) begin bad++; $display("FAIL sres_write_no_pend: got %b want 00", pend); end
        lat0_rd = 1'b1; #1;
        total++; if (snd_din !== 8'h77) begin bad++; $display("FAIL sres_write_latch0: got %h want 77", snd_din); end
        lat0_rd = 1'b0;
        step();
        total++; if (int_n !== 1'b1) begin bad++; $display("FAIL sres_masks_fm: got %b want 1", int_n); end
        ym_irq_n = 1'b1; sres_b = 1'b1;
        step();
        total++; if (pend !== 2'b00) begin bad++; $display("FAIL sres_release_pend: got %b want 00", pend); end
    endtask

    task automatic test_rst_mid();
        main_dout = 8'h42; snd_latch0_cs = 1'b1;
        step(); snd_latch0_cs = 1'b0;
        total++; if (pend !== 2'b01) begin bad++; $display("FAIL rstmid_pre: got %b want 01", pend); end
        rst_n = 1'b0; main_dout = 8'hEE; snd_latch0_cs = 1'b1; snd_latch1_cs = 1'b1;
        snd_int = 1'b1; snd_cen = 1'b1; smp_inc = 1'b1; smp_lo_we = 1'b1; snd_dout = 8'h55;
        step();
        rst_n = 1'b1; snd_latch0_cs = 1'b0; snd_latch1_cs = 1'b0;
        snd_int = 1'b0; snd_cen = 1'b0; smp_inc = 1'b0; smp_lo_we = 1'b0;
        total++; if (pend !== 2'b00) begin bad++; $display("FAIL rstmid_pend: got %b want 00", pend); end
        total++; if (int_n !== 1'b1) begin bad++; $display("FAIL rstmid_int_n: got %b want 1", int_n); end
        total++; if (smp_addr !== 16'h0000) begin bad++; $display("FAIL rstmid_smp: got %h want 0000", smp_addr); end
        lat0_rd = 1'b1; #1;
        total++; if (snd_din !== 8'h00) begin bad++; $display("FAIL rstmid_latch0: got %h want 00", snd_din); end
        lat0_rd = 1'b0; lat1_rd = 1'b1; #1;
        total++; if (snd_din !== 8'h00) begin bad++; $display("FAIL rstmid_latch1: got %h want 00", snd_din); end
        lat1_rd = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; main_dout = 8'h00; snd_latch0_cs = 1'b0; snd_latch1_cs = 1'b0;
        snd_int = 1'b0; sres_b = 1'b1; snd_cen = 1'b0; snd_dout = 8'h00;
        lat0_rd = 1'b0; lat1_rd = 1'b0; irq_ack = 1'b0; ym_irq_n = 1'b1;
        smp_lo_we = 1'b0; smp_hi_we = 1'b0; smp_inc = 1'b0;
        test_reset();
        test_latch0();
        test_latch1();
        test_snd_int();
        test_collision();
        test_sample();
        test_sres();
        test_rst_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
